// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the drain FSM state encoding and the busy-handshake guard limit.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } drainState_e;

    // Cycles to wait in WAIT_HI for uart_tx to raise busy before giving up.
    localparam logic [1:0] UART_BUSY_GUARD = 2'd3;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO storage with wrapping pointers and an occupancy counter.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full_o    = (r_count == FULL_COUNT);
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign rd_data_o = r_mem[r_rdPtr];
    assign w_push    = wr_en_i && !full_o;
    assign w_pop     = rd_en_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain controller feeding uart_tx one byte per busy cycle.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [7:0]            wr_data_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    input  logic                  tx_busy_i,
    output logic                  tx_write_en_o,
    output logic [7:0]            tx_byte_o
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    output logic                  overflow_o,
    input  logic                  overflow_clr_i
`endif
);

    drainState_e r_state;
    drainState_e w_nextState;
    logic [1:0]  r_guard;
    logic [1:0]  w_nextGuard;
    logic [1:0]  w_guardInc;
    logic        r_txWriteEn;
    logic        w_nextWriteEn;
    logic [7:0]  r_txByte;
    logic [7:0]  w_nextByte;
    logic        w_pop;
    logic [7:0]  w_rdData;
    logic        w_full;
    logic        w_empty;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (w_pop),
        .rd_data_o (w_rdData),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (count_o)
    );

    assign full_o        = w_full;
    assign empty_o       = w_empty;
    assign tx_write_en_o = r_txWriteEn;
    assign tx_byte_o     = r_txByte;
    assign w_guardInc    = r_guard + 2'd1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_guard     <= '0;
            r_txWriteEn <= 1'b0;
            r_txByte    <= 8'h00;
        end else begin
            r_state     <= w_nextState;
            r_guard     <= w_nextGuard;
            r_txWriteEn <= w_nextWriteEn;
            r_txByte    <= w_nextByte;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextGuard   = r_guard;
        w_nextWriteEn = 1'b0;
        w_nextByte    = r_txByte;
        w_pop         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty && !tx_busy_i) begin
                    w_nextState   = ISSUE;
                    w_nextWriteEn = 1'b1;
                    w_nextByte    = w_rdData;
                    w_pop         = 1'b1;
                end
            end
            ISSUE: begin
                w_nextState = WAIT_HI;
                w_nextGuard = '0;
            end
            // Give up waiting for busy so a dead downstream cannot stall the queue.
            WAIT_HI: begin
                if (tx_busy_i) begin
                    w_nextState = WAIT_LO;
                end else begin
                    w_nextGuard = w_guardInc;
                    if (w_guardInc == UART_BUSY_GUARD) begin
                        w_nextState = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!tx_busy_i) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic r_overflow;

    assign overflow_o = r_overflow;

    // Set wins over clear so a drop in the clearing cycle is still reported.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_overflow <= 1'b0;
        end else if (wr_en_i && w_full) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr_i) begin
            r_overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with a simple uart_tx busy model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       full_o;
    logic       empty_o;
    logic [4:0] count_o;
    logic       tx_busy_i;
    logic       tx_write_en_o;
    logic [7:0] tx_byte_o;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic       overflow_o;
    logic       overflow_clr_i;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busyCnt = 0;
    int widthErr = 0;
    logic prevWen = 1'b0;
    logic modelEn;
    logic forceBusy;
    logic [7:0] byteQ[$];
    int cycQ[$];

    always #5 clk_i = ~clk_i;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .wr_en_i       (wr_en_i),
        .wr_data_i     (wr_data_i),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .count_o       (count_o),
        .tx_busy_i     (tx_busy_i),
        .tx_write_en_o (tx_write_en_o),
        .tx_byte_o     (tx_byte_o)
`ifdef UART_TX_FIFO_OVERFLOW_EN
        ,
        .overflow_o    (overflow_o),
        .overflow_clr_i(overflow_clr_i)
`endif
    );

    assign tx_busy_i = forceBusy | (modelEn & (busyCnt != 0));

    // uart_tx model: busy rises the cycle after write_en and stays high 20 cycles.
    always @(posedge clk_i) begin
        if (tx_write_en_o) begin
            busyCnt <= 20;
            byteQ.push_back(tx_byte_o);
            cycQ.push_back(cyc);
            if (prevWen) widthErr <= widthErr + 1;
        end else if (busyCnt != 0) begin
            busyCnt <= busyCnt - 1;
        end
        prevWen <= tx_write_en_o;
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] data);
        wr_en_i   = wr;
        wr_data_i = data;
        @(negedge clk_i);
    endtask

    task automatic waitPulses(input int n, input int budget);
        int k = 0;
        while (byteQ.size() < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        checkOutput("pulse_count", byteQ.size(), n);
    endtask

    initial begin
        reset_i   = 1'b1;
        wr_en_i   = 1'b0;
        wr_data_i = 8'h00;
        modelEn   = 1'b0;
        forceBusy = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
        overflow_clr_i = 1'b0;
`endif
        #1;
        $display("[TB] reset state");
        checkOutput("rst_empty", empty_o, 1);
        checkOutput("rst_full", full_o, 0);
        checkOutput("rst_count", count_o, 0);
        checkOutput("rst_wen", tx_write_en_o, 0);
        checkOutput("rst_byte", tx_byte_o, 8'h00);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] single write");
        applyStimulus(1'b1, 8'h55);
        checkOutput("t2_count1", count_o, 1);
        checkOutput("t2_wen_early", tx_write_en_o, 0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t2_wen", tx_write_en_o, 1);
        checkOutput("t2_byte", tx_byte_o, 8'h55);
        checkOutput("t2_count0", count_o, 0);
        @(negedge clk_i);
        checkOutput("t2_wen_drop", tx_write_en_o, 0);
        checkOutput("t2_byte_hold", tx_byte_o, 8'h55);
        repeat (8) @(negedge clk_i);

        $display("[TB] burst of 16 with busy model");
        byteQ.delete();
        cycQ.delete();
        modelEn   = 1'b1;
        forceBusy = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("t3_full", full_o, 1);
        checkOutput("t3_count16", count_o, 16);
        applyStimulus(1'b1, 8'hAA);
        checkOutput("t3_drop_count", count_o, 16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        checkOutput("ovf_set", overflow_o, 1);
        wr_en_i = 1'b0;
        overflow_clr_i = 1'b1;
        @(negedge clk_i);
        overflow_clr_i = 1'b0;
        checkOutput("ovf_clr", overflow_o, 0);
`endif
        forceBusy = 1'b0;
        applyStimulus(1'b0, 8'h00);
        waitPulses(16, 600);
        for (int i = 0; i < 16 && i < byteQ.size(); i++) begin
            checkOutput($sformatf("t3_byte%0d", i), byteQ[i], 8'(i));
            if (i > 0) checkOutput($sformatf("t3_gap%0d", i), (cycQ[i] - cycQ[i-1]) >= 22, 1);
        end
        repeat (30) @(negedge clk_i);
        checkOutput("t3_empty", empty_o, 1);

        $display("[TB] push and pop together, pointer wrap");
        byteQ.delete();
        cycQ.delete();
        modelEn   = 1'b0;
        forceBusy = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h40 + 8'(i));
        checkOutput("t4_count5", count_o, 5);
        forceBusy = 1'b0;
        applyStimulus(1'b1, 8'h45);
        checkOutput("t4_samecycle_count", count_o, 5);
        checkOutput("t4_wen", tx_write_en_o, 1);
        checkOutput("t4_byte", tx_byte_o, 8'h40);
        for (int i = 6; i < 20; i++) begin
            int k = 0;
            wr_en_i = 1'b0;
            while (full_o && k < 50) begin
                @(negedge clk_i);
                k++;
            end
            applyStimulus(1'b1, 8'h40 + 8'(i));
        end
        applyStimulus(1'b0, 8'h00);
        waitPulses(20, 400);
        for (int i = 0; i < 20 && i < byteQ.size(); i++)
            checkOutput($sformatf("t4_byte%0d", i), byteQ[i], 8'h40 + 8'(i));
        repeat (10) @(negedge clk_i);
        checkOutput("t4_empty", empty_o, 1);

        $display("[TB] guard timeout with busy tied low");
        byteQ.delete();
        cycQ.delete();
        forceBusy = 1'b1;
        applyStimulus(1'b1, 8'hA1);
        applyStimulus(1'b1, 8'hA2);
        forceBusy = 1'b0;
        applyStimulus(1'b0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk_i);
            checkOutput($sformatf("t5_wen%0d", k), tx_write_en_o, (k == 0 || k == 5) ? 1 : 0);
        end
        checkOutput("t5_byte2", tx_byte_o, 8'hA2);
        checkOutput("t5_width", widthErr, 0);

        $display("[TB] async reset mid-burst");
        repeat (10) @(negedge clk_i);
        forceBusy = 1'b1;
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h70 + 8'(i));
        wr_en_i = 1'b0;
        checkOutput("t6_count7", count_o, 7);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("t6_count", count_o, 0);
        checkOutput("t6_empty", empty_o, 1);
        checkOutput("t6_full", full_o, 0);
        checkOutput("t6_wen", tx_write_en_o, 0);
        checkOutput("t6_byte", tx_byte_o, 8'h00);
        forceBusy = 1'b0;
        byteQ.delete();
        cycQ.delete();
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (30) @(negedge clk_i);
        checkOutput("t6_no_pulse", byteQ.size(), 0);
        checkOutput("t6_still_empty", empty_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO plus drain controller that sits directly upstream of uart_tx.
- Accepts bytes from the application side at full clock rate.
- Feeds them one at a time to uart_tx through its write_en_i / byte_i / busy_o handshake.
- Decouples bursty producers (command responders, printf-style loggers) from the 9600-baud serial line.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries); legal range 1..8

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous active-high reset
wr_en_i  input  1  producer write strobe; byte accepted iff full_o=0 in the same cycle
wr_data_i  input  8  producer byte
full_o  output  1  FIFO holds DEPTH entries
empty_o  output  1  FIFO holds 0 entries
count_o  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
tx_busy_i  input  1  uart_tx busy_o
tx_write_en_o  output  1  one-cycle pulse to uart_tx write_en_i
tx_byte_o  output  8  byte to uart_tx byte_i; valid while tx_write_en_o=1, held afterwards

Behaviour:
Clock and reset
- One clock: clk_i. Reset: reset_i, asynchronous, active-high.
- All flops reset asynchronously: rd_ptr=0, wr_ptr=0, count=0, state=IDLE, guard=0.
- Output reset values: tx_write_en_o=0, tx_byte_o=8'h00, full_o=0, empty_o=1, count_o=0.
- Reset mid-operation discards all queued bytes. Any pulse already issued is not retracted; uart_tx shares the same reset.

Storage and pointers
- DEPTH x 8 register array.
- Pointers are DEPTH_LOG2 bits and wrap naturally (DEPTH-1 -> 0).
- count is DEPTH_LOG2+1 bits.
- full_o, empty_o and count_o are all derived from the registered count.

Write side
- Push when wr_en_i=1 and full_o=0: mem[wr_ptr] <= wr_data_i, wr_ptr++.
- Write while full: silently dropped; no state change.
- A push is qualified by the registered full_o only, so a write while full is dropped even if a pop happens in the same cycle.

Drain FSM, 4 states
- IDLE: if empty_o=0 and tx_busy_i=0, then on the next edge: tx_write_en_o<=1, tx_byte_o<=mem[rd_ptr], rd_ptr++, pop; go to ISSUE. Otherwise stay in IDLE.
- ISSUE: tx_write_en_o<=0, guard<=0; go to WAIT_HI. The pulse is exactly 1 cycle wide.
- WAIT_HI: if tx_busy_i=1, go to WAIT_LO. Otherwise guard++; when guard reaches 3, return to IDLE. This timeout protects against a missing or held-in-reset downstream.
- WAIT_LO: on tx_busy_i=0, go to IDLE.

Count update
- Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.

Latency and throughput
- Write to an empty FIFO while IDLE with tx idle: tx_write_en_o asserts in the cycle after the write edge (1-cycle latency).
- Inter-frame gap from busy falling to the next pulse: 1 cycle in IDLE, then the pulse.
- Rate is therefore limited only by uart_tx.
- Empty and full cannot both be true. DEPTH=2**DEPTH_LOG2 is always at least 2.

Optional Feature:
Macro UART_TX_FIFO_OVERFLOW_EN.
- Defined:
  - Adds ports overflow_o (output, 1) and overflow_clr_i (input, 1).
  - overflow_o is sticky: set on the edge after any wr_en_i=1 while full_o=1.
  - Cleared by overflow_clr_i=1. Set has priority if both occur in the same cycle.
  - Resets to 0.
- Undefined: the ports do not exist; dropped writes are unreported.

Decomposition:
Package uart_pkg holds:
- drain FSM typedef: enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO};
- constant UART_BUSY_GUARD = 2'd3;
- existing baud constants, if any, move here as well.

One natural sub-module: sync_fifo (parameterised width/depth storage, pointers and count, full/empty).
- uart_tx_fifo instantiates sync_fifo and contains only the drain FSM and output registers.

Test Plan:
1. Reset with a 16-deep FIFO -> empty_o=1, full_o=0, count_o=0, tx_write_en_o=0, tx_byte_o=8'h00.
2. Single write 8'h55 with tx_busy_i=0 -> tx_write_en_o=1 for exactly one cycle, one cycle after the write, with tx_byte_o=8'h55; count_o goes 1 -> 0.
3. Burst of 16 writes 8'h00..8'h0F against a uart_tx model that raises busy the cycle after write_en and holds it for 20 cycles:
   - full_o=1 after the 16th write;
   - 17th write (8'hAA) dropped;
   - bytes emitted in order 00..0F, each pulse separated by at least 22 cycles;
   - empty_o=1 at the end.
4. Simultaneous push and pop at count=5 -> count_o stays 5; pointers wrap correctly across entry 15 -> 0 on a 20-byte stream.
5. tx_busy_i tied 0 with 2 bytes queued -> FSM returns to IDLE 4 cycles after ISSUE via the guard; the second byte is issued next with no hang.
6. reset_i asserted asynchronously mid-burst with count_o=7 -> outputs return to reset values immediately, with no further tx_write_en_o.
   With UART_TX_FIFO_OVERFLOW_EN, a write while full sets overflow_o=1, and overflow_clr_i clears it.
